// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed neuron layer engines.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_IDENT = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_RAM,
        S_RD_BIAS,
        S_RD_OPND,
        S_REQ_MULT,
        S_WAIT_MULT,
        S_REQ_OUT,
        S_WRITE
    } nn_state_e;

    function automatic int nn_acc_width(input int data_width, input int num_inputs);
        return 2 * data_width + $clog2(num_inputs + 1);
    endfunction

endpackage

// File: rtl/nn_activation.sv
// Accumulator-to-output path: fixed-point rescale, activation, width reduction.
// NN_SAT_EN selects saturation instead of two's-complement wrap.
module nn_activation
    import nn_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int AccWidth  = 19,
    parameter int FracBits  = 0
) (
    input  logic [1:0]                 i_mode,
    input  logic signed [AccWidth-1:0] i_acc,
    output logic [DataWidth-1:0]       o_y
);

    logic signed [AccWidth-1:0] w_sh;
    logic signed [AccWidth-1:0] w_act;

    assign w_sh = i_acc >>> FracBits;

    always_comb begin
        w_act = w_sh;
        unique case (act_mode_e'(i_mode))
            ACT_IDENT: w_act = w_sh;
            ACT_LEAKY: w_act = w_sh[AccWidth-1] ? (w_sh >>> 3) : w_sh;
            default:   w_act = w_sh[AccWidth-1] ? '0 : w_sh;
        endcase
    end

`ifdef NN_SAT_EN
    localparam logic signed [AccWidth-1:0] MaxV = AccWidth'((2 ** (DataWidth - 1)) - 1);
    localparam logic signed [AccWidth-1:0] MinV = -MaxV - AccWidth'(1);

    always_comb begin
        if (w_act > MaxV) begin
            o_y = MaxV[DataWidth-1:0];
        end else if (w_act < MinV) begin
            o_y = MinV[DataWidth-1:0];
        end else begin
            o_y = w_act[DataWidth-1:0];
        end
    end
`else
    assign o_y = DataWidth'(w_act);
`endif

endmodule

// File: rtl/neuron_seq_mac.sv
// Sequential neuron layer: y[n] = act(bias + sum w*x) over shared RAMs and multiplier.
// Define NN_SAT_EN to saturate outputs instead of wrapping.
module neuron_seq_mac
    import nn_pkg::*;
#(
    parameter int NumInputs  = 4,
    parameter int NumNeurons = 4,
    parameter int DataWidth  = 8,
    parameter int FracBits   = 0,
    parameter int AddrWidth  = 8,
    parameter int InBase     = 0,
    parameter int WgtBase    = 0,
    parameter int OutBase    = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [1:0]             act_mode_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   in_actv_req_o,
    input  logic                   in_actv_grant_i,
    output logic [AddrWidth-1:0]   in_actv_addr_o,
    input  logic [DataWidth-1:0]   in_actv_din_i,
    output logic                   wgt_req_o,
    input  logic                   wgt_grant_i,
    output logic [AddrWidth-1:0]   wgt_addr_o,
    input  logic [DataWidth-1:0]   wgt_din_i,
    output logic                   out_actv_req_o,
    input  logic                   out_actv_grant_i,
    output logic [AddrWidth-1:0]   out_actv_addr_o,
    output logic                   out_actv_we_o,
    output logic [DataWidth-1:0]   out_actv_dout_o,
    output logic                   mult_req_o,
    input  logic                   mult_grant_i,
    output logic                   mult_start_o,
    output logic [DataWidth-1:0]   mult_a_o,
    output logic [DataWidth-1:0]   mult_b_o,
    input  logic                   mult_done_i,
    input  logic [2*DataWidth-1:0] mult_result_i
);

    localparam int AccWidth = nn_acc_width(DataWidth, NumInputs);
    localparam logic [AddrWidth-1:0] LastIn = AddrWidth'(NumInputs - 1);
    localparam logic [AddrWidth-1:0] LastN  = AddrWidth'(NumNeurons - 1);
    localparam logic [AddrWidth-1:0] Stride = AddrWidth'(NumInputs + 1);

    nn_state_e                  r_state;
    act_mode_e                  r_mode;
    logic [AddrWidth-1:0]       r_n;
    logic [AddrWidth-1:0]       r_i;
    logic signed [AccWidth-1:0] r_acc;
    logic [DataWidth-1:0]       r_a;
    logic [DataWidth-1:0]       r_b;
    logic [DataWidth-1:0]       r_dout;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_in_req;
    logic                       r_wgt_req;
    logic                       r_mult_req;
    logic                       r_out_req;
    logic                       r_we;

    logic                       w_ram_gnt;
    logic [AddrWidth-1:0]       w_bias_addr;
    logic [AddrWidth-1:0]       w_in_addr;
    logic [AddrWidth-1:0]       w_wgt_addr;
    logic [AddrWidth-1:0]       w_out_addr;
    logic signed [AccWidth-1:0] w_bias_ext;
    logic signed [AccWidth-1:0] w_prod_ext;
    logic [DataWidth-1:0]       w_act_y;

    assign w_ram_gnt   = in_actv_grant_i & wgt_grant_i;
    assign w_bias_addr = AddrWidth'(WgtBase) + r_n * Stride;
    assign w_bias_ext  = {{(AccWidth-DataWidth){wgt_din_i[DataWidth-1]}}, wgt_din_i};
    assign w_prod_ext  = {{(AccWidth-2*DataWidth){mult_result_i[2*DataWidth-1]}}, mult_result_i};

    // Addresses follow the counters so they hold still while a grant is pending.
    always_comb begin
        w_in_addr  = '0;
        w_wgt_addr = '0;
        w_out_addr = '0;
        if (r_state != S_IDLE) begin
            w_in_addr  = AddrWidth'(InBase) + r_i;
            w_out_addr = AddrWidth'(OutBase) + r_n;
            if (r_state == S_REQ_RAM && r_i == '0) begin
                w_wgt_addr = w_bias_addr;
            end else begin
                w_wgt_addr = w_bias_addr + AddrWidth'(1) + r_i;
            end
        end
    end

    nn_activation #(
        .DataWidth (DataWidth),
        .AccWidth  (AccWidth),
        .FracBits  (FracBits)
    ) u_act (
        .i_mode (r_mode),
        .i_acc  (r_acc),
        .o_y    (w_act_y)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_mode     <= ACT_IDENT;
            r_n        <= '0;
            r_i        <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_dout     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_in_req   <= 1'b0;
            r_wgt_req  <= 1'b0;
            r_mult_req <= 1'b0;
            r_out_req  <= 1'b0;
            r_we       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_mode    <= act_mode_e'(act_mode_i);
                        r_n       <= '0;
                        r_i       <= '0;
                        r_busy    <= 1'b1;
                        r_in_req  <= 1'b1;
                        r_wgt_req <= 1'b1;
                        r_state   <= S_REQ_RAM;
                    end
                end
                S_REQ_RAM: begin
                    if (w_ram_gnt) begin
                        r_state <= (r_i == '0) ? S_RD_BIAS : S_RD_OPND;
                    end
                end
                S_RD_BIAS: begin
                    r_acc   <= w_bias_ext <<< FracBits;
                    r_state <= S_RD_OPND;
                end
                S_RD_OPND: begin
                    r_a        <= in_actv_din_i;
                    r_b        <= wgt_din_i;
                    r_in_req   <= 1'b0;
                    r_wgt_req  <= 1'b0;
                    r_mult_req <= 1'b1;
                    r_state    <= S_REQ_MULT;
                end
                S_REQ_MULT: begin
                    if (mult_grant_i) begin
                        r_state <= S_WAIT_MULT;
                    end
                end
                S_WAIT_MULT: begin
                    if (mult_done_i) begin
                        r_acc      <= r_acc + w_prod_ext;
                        r_mult_req <= 1'b0;
                        if (r_i == LastIn) begin
                            r_out_req <= 1'b1;
                            r_state   <= S_REQ_OUT;
                        end else begin
                            r_i       <= r_i + AddrWidth'(1);
                            r_in_req  <= 1'b1;
                            r_wgt_req <= 1'b1;
                            r_state   <= S_REQ_RAM;
                        end
                    end
                end
                S_REQ_OUT: begin
                    if (out_actv_grant_i) begin
                        r_we    <= 1'b1;
                        r_dout  <= w_act_y;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_out_req <= 1'b0;
                    r_i       <= '0;
                    if (r_n == LastN) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_n       <= r_n + AddrWidth'(1);
                        r_in_req  <= 1'b1;
                        r_wgt_req <= 1'b1;
                        r_state   <= S_REQ_RAM;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign in_actv_req_o   = r_in_req;
    assign in_actv_addr_o  = w_in_addr;
    assign wgt_req_o       = r_wgt_req;
    assign wgt_addr_o      = w_wgt_addr;
    assign out_actv_req_o  = r_out_req;
    assign out_actv_addr_o = w_out_addr;
    assign out_actv_we_o   = r_we;
    assign out_actv_dout_o = r_dout;
    assign mult_req_o      = r_mult_req;
    assign mult_start_o    = (r_state == S_REQ_MULT) & mult_grant_i;
    assign mult_a_o        = r_a;
    assign mult_b_o        = r_b;

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Scoreboard bench for neuron_seq_mac: RAM/multiplier models, grant stalls, mid-layer reset.
`timescale 1ns/1ps
module tb_neuron_seq_mac;

    localparam int NI = 2;
    localparam int NN = 2;
    localparam int DW = 8;
    localparam int FB = 0;
    localparam int AW = 8;
    localparam int IB = 4;
    localparam int WB = 16;
    localparam int OB = 40;

    localparam int K_IMM    = 0;
    localparam int K_RND    = 1;
    localparam int K_WSTALL = 2;
    localparam int K_MSTALL = 3;
    localparam int K_BUSY   = 4;
    localparam int K_RST    = 5;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [1:0]    act_mode_i;
    logic          busy_o, done_o;
    logic          in_actv_req_o, in_actv_grant_i;
    logic [AW-1:0] in_actv_addr_o;
    logic [DW-1:0] in_actv_din_i;
    logic          wgt_req_o, wgt_grant_i;
    logic [AW-1:0] wgt_addr_o;
    logic [DW-1:0] wgt_din_i;
    logic          out_actv_req_o, out_actv_grant_i;
    logic [AW-1:0] out_actv_addr_o;
    logic          out_actv_we_o;
    logic [DW-1:0] out_actv_dout_o;
    logic          mult_req_o, mult_grant_i, mult_start_o;
    logic [DW-1:0] mult_a_o, mult_b_o;
    logic          mult_done_i;
    logic [2*DW-1:0] mult_result_i;

    logic g_in_en, g_wgt_en, g_out_en, g_mult_en;
    logic stop;

    logic [DW-1:0] in_mem  [256];
    logic [DW-1:0] wgt_mem [256];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    int n_checks, n_fail;
    int done_cnt, ms_cnt, wr_cnt;
    logic prev_we;

    int gx [NI];
    int gb [NN];
    int gw [NN][NI];

    always #5 clk = ~clk;

    assign in_actv_grant_i  = in_actv_req_o & g_in_en;
    assign wgt_grant_i      = wgt_req_o & g_wgt_en;
    assign out_actv_grant_i = out_actv_req_o & g_out_en;
    assign mult_grant_i     = mult_req_o & g_mult_en;

    neuron_seq_mac #(
        .NumInputs  (NI),
        .NumNeurons (NN),
        .DataWidth  (DW),
        .FracBits   (FB),
        .AddrWidth  (AW),
        .InBase     (IB),
        .WgtBase    (WB),
        .OutBase    (OB)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .act_mode_i       (act_mode_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .in_actv_req_o    (in_actv_req_o),
        .in_actv_grant_i  (in_actv_grant_i),
        .in_actv_addr_o   (in_actv_addr_o),
        .in_actv_din_i    (in_actv_din_i),
        .wgt_req_o        (wgt_req_o),
        .wgt_grant_i      (wgt_grant_i),
        .wgt_addr_o       (wgt_addr_o),
        .wgt_din_i        (wgt_din_i),
        .out_actv_req_o   (out_actv_req_o),
        .out_actv_grant_i (out_actv_grant_i),
        .out_actv_addr_o  (out_actv_addr_o),
        .out_actv_we_o    (out_actv_we_o),
        .out_actv_dout_o  (out_actv_dout_o),
        .mult_req_o       (mult_req_o),
        .mult_grant_i     (mult_grant_i),
        .mult_start_o     (mult_start_o),
        .mult_a_o         (mult_a_o),
        .mult_b_o         (mult_b_o),
        .mult_done_i      (mult_done_i),
        .mult_result_i    (mult_result_i)
    );

    // Synchronous-read RAMs and a one-cycle multiplier.
    always @(posedge clk) begin
        in_actv_din_i <= in_mem[in_actv_addr_o];
        wgt_din_i     <= wgt_mem[wgt_addr_o];
    end

    always @(posedge clk) begin
        if (reset_i) begin
            mult_done_i   <= 1'b0;
            mult_result_i <= '0;
        end else begin
            mult_done_i <= mult_start_o;
            if (mult_start_o)
                mult_result_i <= $signed({{DW{mult_a_o[DW-1]}}, mult_a_o})
                               * $signed({{DW{mult_b_o[DW-1]}}, mult_b_o});
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic of the layer equation.
    function automatic logic [DW-1:0] ref_y(input int acc, input int mode);
        int v;
        v = acc >>> FB;
        if (mode == 0) begin
            v = v;
        end else if (mode == 2) begin
            if (v < 0) v = v >>> 3;
        end else begin
            if (v < 0) v = 0;
        end
`ifdef NN_SAT_EN
        if (v > 127) v = 127;
        if (v < -128) v = -128;
`endif
        return DW'(v);
    endfunction

    // Monitor: counts events and pops the scoreboard on every write.
    initial begin
        wr_t e;
        done_cnt = 0;
        ms_cnt   = 0;
        wr_cnt   = 0;
        prev_we  = 1'b0;
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (mult_start_o) ms_cnt++;
            if (out_actv_we_o) begin
                wr_cnt++;
                check("we_single_cycle", 32'(prev_we), 0);
                check("we_with_req", 32'(out_actv_req_o), 1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                             out_actv_addr_o, out_actv_dout_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(out_actv_addr_o), 32'(e.addr));
                    check("wr_data", 32'(out_actv_dout_o), 32'(e.data));
                end
            end
            prev_we = out_actv_we_o;
        end
    end

    task automatic drive_grants(input int kind);
        int c;
        logic [AW-1:0] wa, ia;
        if (kind == K_WSTALL) begin
            c = 0;
            while (!wgt_req_o && c < 50) begin @(negedge clk); c++; end
            check("wstall_req_seen", 32'(c < 50), 1);
            @(negedge clk);
            wa = wgt_addr_o;
            ia = in_actv_addr_o;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("wstall_wgt_addr", 32'(wgt_addr_o), 32'(wa));
                check("wstall_in_addr", 32'(in_actv_addr_o), 32'(ia));
                check("wstall_no_mreq", 32'(mult_req_o), 0);
            end
            @(posedge clk);
            #1 g_wgt_en = 1'b1;
        end else if (kind == K_MSTALL) begin
            c = 0;
            while (!mult_req_o && c < 80) begin @(negedge clk); c++; end
            check("mstall_req_seen", 32'(c < 80), 1);
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                check("mstall_no_start", 32'(mult_start_o), 0);
                check("mstall_req_held", 32'(mult_req_o), 1);
            end
            @(posedge clk);
            #1 g_mult_en = 1'b1;
            @(negedge clk);
            check("mstall_start_on_grant", 32'(mult_start_o), 1);
        end
        while (!stop) begin
            @(posedge clk);
            #1;
            if (kind == K_RND && !stop) begin
                g_in_en   = ($urandom_range(0, 3) != 0);
                g_wgt_en  = ($urandom_range(0, 3) != 0);
                g_out_en  = ($urandom_range(0, 3) != 0);
                g_mult_en = ($urandom_range(0, 3) != 0);
            end
        end
        g_in_en   = 1'b1;
        g_wgt_en  = 1'b1;
        g_out_en  = 1'b1;
        g_mult_en = 1'b1;
    endtask

    task automatic finish_layer(input int kind, input int mode, input int d0, input int w0);
        int c;
        if (kind == K_RST) begin
            c = 0;
            while (wr_cnt == w0 && c < 400) begin @(negedge clk); c++; end
            check("rst_first_write", 32'(c < 400), 1);
            c = 0;
            while (!mult_done_i && c < 100) begin @(negedge clk); c++; end
            check("rst_wait_mult", 32'(c < 100), 1);
            reset_i = 1'b1;
            @(negedge clk);
            check("rst_in_req", 32'(in_actv_req_o), 0);
            check("rst_wgt_req", 32'(wgt_req_o), 0);
            check("rst_mult_req", 32'(mult_req_o), 0);
            check("rst_out_req", 32'(out_actv_req_o), 0);
            check("rst_mult_start", 32'(mult_start_o), 0);
            check("rst_we", 32'(out_actv_we_o), 0);
            check("rst_busy", 32'(busy_o), 0);
            reset_i = 1'b0;
            repeat (20) @(negedge clk);
        end else begin
            if (kind == K_BUSY) begin
                repeat (8) @(negedge clk);
                check("busy_before_restart", 32'(busy_o), 1);
                act_mode_i = 2'(mode + 1);
                start_i    = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
            c = 0;
            while (done_cnt == d0 && c < 600) begin @(negedge clk); c++; end
            check("done_timeout", 32'(c < 600), 1);
            repeat (6) @(negedge clk);
        end
        stop = 1'b1;
    endtask

    task automatic run_layer(input int mode, input int kind);
        int  acc;
        wr_t e;
        int  d0, m0, w0;
        for (int i = 0; i < NI; i++) in_mem[IB + i] = DW'(gx[i]);
        for (int n = 0; n < NN; n++) begin
            wgt_mem[WB + n * (NI + 1)] = DW'(gb[n]);
            acc = gb[n];
            for (int i = 0; i < NI; i++) begin
                wgt_mem[WB + n * (NI + 1) + 1 + i] = DW'(gw[n][i]);
                acc += gw[n][i] * gx[i];
            end
            e.addr = AW'(OB + n);
            e.data = ref_y(acc, mode);
            if (!(kind == K_RST && n > 0)) exp_q.push_back(e);
        end
        g_in_en   = 1'b1;
        g_out_en  = 1'b1;
        g_wgt_en  = (kind != K_WSTALL);
        g_mult_en = (kind != K_MSTALL);
        stop = 1'b0;
        d0 = done_cnt;
        m0 = ms_cnt;
        w0 = wr_cnt;
        @(negedge clk);
        act_mode_i = 2'(mode);
        start_i    = 1'b1;
        @(negedge clk);
        start_i    = 1'b0;
        act_mode_i = 2'(mode + 1);
        check("busy_after_start", 32'(busy_o), 1);
        fork
            drive_grants(kind);
            finish_layer(kind, mode, d0, w0);
        join
        check("sb_drain", 32'(exp_q.size()), 0);
        if (kind == K_RST) begin
            check("rst_no_done", 32'(done_cnt - d0), 0);
            check("rst_one_write", 32'(wr_cnt - w0), 1);
        end else begin
            check("done_once", 32'(done_cnt - d0), 1);
            check("mult_starts", 32'(ms_cnt - m0), 32'(NI * NN));
            check("writes", 32'(wr_cnt - w0), 32'(NN));
            check("busy_idle", 32'(busy_o), 0);
        end
        exp_q.delete();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset_i    = 1'b1;
        start_i    = 1'b0;
        act_mode_i = 2'd0;
        g_in_en    = 1'b1;
        g_wgt_en   = 1'b1;
        g_out_en   = 1'b1;
        g_mult_en  = 1'b1;
        stop       = 1'b0;
        for (int a = 0; a < 256; a++) begin
            in_mem[a]  = '0;
            wgt_mem[a] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy_o", 32'(busy_o), 0);
        check("rst_done_o", 32'(done_o), 0);
        check("rst_in_req_o", 32'(in_actv_req_o), 0);
        check("rst_in_addr_o", 32'(in_actv_addr_o), 0);
        check("rst_wgt_req_o", 32'(wgt_req_o), 0);
        check("rst_wgt_addr_o", 32'(wgt_addr_o), 0);
        check("rst_out_req_o", 32'(out_actv_req_o), 0);
        check("rst_out_addr_o", 32'(out_actv_addr_o), 0);
        check("rst_out_we_o", 32'(out_actv_we_o), 0);
        check("rst_out_dout_o", 32'(out_actv_dout_o), 0);
        check("rst_mult_req_o", 32'(mult_req_o), 0);
        check("rst_mult_start_o", 32'(mult_start_o), 0);
        check("rst_mult_a_o", 32'(mult_a_o), 0);
        check("rst_mult_b_o", 32'(mult_b_o), 0);
        reset_i = 1'b0;
        @(negedge clk);

        gx = '{3, 4};
        gb = '{1, -20};
        gw = '{'{2, -1}, '{1, 1}};
        run_layer(1, K_IMM);
        run_layer(0, K_IMM);
        run_layer(2, K_IMM);
        run_layer(3, K_IMM);
        run_layer(1, K_WSTALL);
        run_layer(0, K_MSTALL);
        run_layer(0, K_BUSY);

        gx = '{100, 100};
        gb = '{0, 0};
        gw = '{'{100, 100}, '{100, 100}};
        run_layer(0, K_IMM);

        gx = '{-128, -128};
        gb = '{127, -128};
        gw = '{'{-128, -128}, '{127, 127}};
        run_layer(0, K_IMM);
        run_layer(2, K_IMM);

        gx = '{3, 4};
        gb = '{1, -20};
        gw = '{'{2, -1}, '{1, 1}};
        run_layer(1, K_RST);
        run_layer(0, K_IMM);

        for (int t = 0; t < 14; t++) begin
            for (int i = 0; i < NI; i++) gx[i] = int'($urandom_range(0, 255)) - 128;
            for (int n = 0; n < NN; n++) begin
                gb[n] = int'($urandom_range(0, 255)) - 128;
                for (int i = 0; i < NI; i++) gw[n][i] = int'($urandom_range(0, 255)) - 128;
            end
            run_layer(int'($urandom_range(0, 3)), (t % 2 == 0) ? K_RND : K_IMM);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
